sound_sequencer: RTL



---
 rtl/sound_pkg.sv | 58 +++++
 rtl/tone_gen.sv | 33 +++
 rtl/sound_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and the melody ROM for the snake game sound sequencer.
// Half periods in the ROM assume a 12 MHz system clock.
package sound_pkg;

  // Event codes double as priority: a higher code wins arbitration.
  typedef enum logic [1:0] {
    EV_GOOD  = 2'd0,
    EV_LEVEL = 2'd1,
    EV_BAD   = 2'd2,
    EV_OVER  = 2'd3
  } ev_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [15:0] half_period;
    logic [7:0]  dur_ticks;
    logic        last;
  } note_t;

  localparam int ROM_DEPTH = 8;

  // Melodies laid out back to back: good, bad, level (3 notes), over (3 notes).
  localparam note_t MELODY_ROM [ROM_DEPTH] = '{
    '{16'd13636, 8'd25, 1'b1},   // good  : 440 Hz
    '{16'd24000, 8'd83, 1'b1},   // bad   : 250 Hz
    '{16'd11472, 8'd10, 1'b0},   // level : rising triad
    '{16'd9105,  8'd10, 1'b0},
    '{16'd7653,  8'd10, 1'b1},
    '{16'd15306, 8'd20, 1'b0},   // over  : falling triad
    '{16'd18182, 8'd20, 1'b0},
    '{16'd22901, 8'd20, 1'b1}
  };

  // First ROM address of each event's melody.
  function automatic logic [2:0] ev_start(input ev_e ev);
    case (ev)
      EV_GOOD:  ev_start = 3'd0;
      EV_BAD:   ev_start = 3'd1;
      EV_LEVEL: ev_start = 3'd2;
      default:  ev_start = 3'd5;
    endcase
  endfunction

  // Highest-priority set bit of the pending vector (bit index == event code).
  function automatic ev_e pick_highest(input logic [3:0] pend);
    if (pend[3])      pick_highest = EV_OVER;
    else if (pend[2]) pick_highest = EV_BAD;
    else if (pend[1]) pick_highest = EV_LEVEL;
    else              pick_highest = EV_GOOD;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: toggles every half_period cycles while enabled.
// Disabling clears both the divider and the output phase so every note starts
// low and the speaker is silent outside a note.
module tone_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] half_period,
  input  logic        enable,
  input  logic        mute,
  output logic        tone_out
);

  logic [15:0] cnt_q;
  logic        toggle_q;

  // Half-period divider and output phase register.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst || !enable) begin
      cnt_q    <= '0;
      toggle_q <= 1'b0;
    end else if (cnt_q == half_period - 16'd1) begin
      cnt_q    <= '0;
      toggle_q <= ~toggle_q;
    end else begin
      cnt_q    <= cnt_q + 16'd1;
    end
  end

  assign tone_out = toggle_q & ~mute;

endmodule

// File: rtl/sound_sequencer.sv
// Sound sequencer: latches game-event pulses, arbitrates by fixed priority
// (over > bad > level > good) and plays each event's melody through one
// shared tone generator.
// Optional build macro SOUND_PREEMPT_EN: a pending event of strictly higher
// priority than the one playing aborts the current melody at the next edge.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 120000,
  parameter int GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_good,
  input  logic       ev_bad,
  input  logic       ev_level,
  input  logic       ev_over,
  input  logic       mute,
  output logic       busy,
  output logic [1:0] active_ev,
  output logic [1:0] note_idx,
  output logic       tone_out
);

  localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]     GAP_LAST  = (GAP_TICKS > 0) ? 8'(GAP_TICKS - 1) : 8'd0;
  localparam bit             HAS_GAP   = (GAP_TICKS > 0);

  state_e        state_q, state_d;
  logic [3:0]    pending_q;
  logic [3:0]    pend_set;
  logic [3:0]    pend_clr;
  logic          pend_any;
  ev_e           sel_ev;
  ev_e           ev_q;
  logic [1:0]    note_idx_q;
  note_t         cur_note;
  logic [2:0]    rom_addr;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    note_tick;
  logic          tick_wrap;
  logic          play_done;
  logic          gap_done;
  logic          note_end;
  logic          preempt;
  logic          take;
  logic          tone_en;

  // Bit index of the pending vector equals the event code.
  assign pend_set = {ev_over, ev_bad, ev_level, ev_good};
  assign pend_any = |pending_q;
  assign sel_ev   = pick_highest(pending_q);
  assign rom_addr = ev_start(ev_q) + {1'b0, note_idx_q};

`ifdef SOUND_PREEMPT_EN
  assign preempt = (state_q != ST_IDLE) && pend_any && (sel_ev > ev_q);
`else
  assign preempt = 1'b0;
`endif

  // A new melody starts either from IDLE or by preempting the current one.
  assign take = ((state_q == ST_IDLE) && pend_any) || preempt;

  assign tick_wrap = (tick_cnt == TICK_LAST);
  assign play_done = (state_q == ST_PLAY) && tick_wrap &&
                     (note_tick == cur_note.dur_ticks - 8'd1);
  assign gap_done  = (state_q == ST_GAP) && tick_wrap && (note_tick == GAP_LAST);
  assign note_end  = HAS_GAP ? gap_done : play_done;

  // Clear mask for the event being selected this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    pend_clr = '0;
    if (take) pend_clr[sel_ev] = 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pend_any) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_PLAY;
      ST_PLAY: begin
        if (play_done) begin
          if (HAS_GAP)            state_d = ST_GAP;
          else if (cur_note.last) state_d = ST_IDLE;
          else                    state_d = ST_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_done) state_d = cur_note.last ? ST_IDLE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
    if (preempt) state_d = ST_LOAD;
  end

  // FSM outputs; the tone runs only while PLAY is both current and next, so
  // it starts counting on PLAY entry and drops on the edge that leaves PLAY.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    tone_en = (state_q == ST_PLAY) && (state_d == ST_PLAY);
  end

  // Pending latch, melody position, note latch and duration counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      ev_q       <= EV_GOOD;
      note_idx_q <= '0;
      cur_note   <= '0;
      tick_cnt   <= '0;
      note_tick  <= '0;
    end else begin
      // Set wins over clear when both hit the same bit.
      pending_q <= (pending_q & ~pend_clr) | pend_set;
      if (take) begin
        ev_q       <= sel_ev;
        note_idx_q <= '0;
        tick_cnt   <= '0;
        note_tick  <= '0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            cur_note  <= MELODY_ROM[rom_addr];
            tick_cnt  <= '0;
            note_tick <= '0;
          end
          ST_PLAY, ST_GAP: begin
            if (tick_wrap) begin
              tick_cnt  <= '0;
              note_tick <= (play_done || gap_done) ? 8'd0 : note_tick + 8'd1;
            end else begin
              tick_cnt  <= tick_cnt + TW'(1);
            end
          end
          default: ;
        endcase
        if (note_end) begin
          if (cur_note.last) begin
            ev_q       <= EV_GOOD;
            note_idx_q <= '0;
          end else begin
            note_idx_q <= note_idx_q + 2'd1;
          end
        end
      end
    end
  end

  assign active_ev = ev_q;
  assign note_idx  = note_idx_q;

  tone_gen u_tone_gen (
    .clk         (clk),
    .rst         (rst),
    .half_period (cur_note.half_period),
    .enable      (tone_en),
    .mute        (mute),
    .tone_out    (tone_out)
  );

endmodule
